// File: rtl/ddr_deser_align.sv
// Multi-lane DDR deserialiser: builds RATIO-bit words from Q1/Q2 pairs and trains a per-lane bit offset.
// Latency: one clock from the last bit of a word to DATA_VALID / DATA_OUT.
// Backpressure: none; CE low freezes the whole datapath and every FSM without losing state.
module ddr_deser_align #(
    parameter int                LANES         = 4,
    parameter int                RATIO         = 8,
    parameter logic [RATIO-1:0]  TRAIN_PATTERN = RATIO'(8'hA5),
    parameter int                LOCK_COUNT    = 16
) (
    input  logic                           C,
    input  logic                           RN,
    input  logic                           CE,
    input  logic [LANES-1:0]               Q1,
    input  logic [LANES-1:0]               Q2,
    input  logic                           TRAIN_EN,
    output logic [LANES*RATIO-1:0]         DATA_OUT,
    output logic                           DATA_VALID,
    output logic [LANES*$clog2(RATIO)-1:0] OFFSET,
    output logic [LANES-1:0]               LOCKED,
    output logic [LANES-1:0]               ERROR
);

    localparam int OW   = $clog2(RATIO);
    localparam int HALF = RATIO / 2;
    localparam int PW   = $clog2(HALF);
    localparam int MW   = $clog2(LOCK_COUNT + 1);
    localparam int SW   = $clog2(RATIO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_LOCK,
        S_FAIL
    } state_t;

    logic [PW-1:0] phase;
    logic          strobe;
    logic          train_q;
    logic          train_rise;
    logic          dv_q;

    assign strobe     = CE && (phase == PW'(HALF - 1));
    assign train_rise = CE && TRAIN_EN && !train_q;
    // The pending strobe survives a CE-low stall and is presented once CE returns.
    assign DATA_VALID = dv_q && CE;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            phase   <= '0;
            train_q <= 1'b0;
            dv_q    <= 1'b0;
        end else if (CE) begin
            phase   <= strobe ? '0 : phase + 1'b1;
            train_q <= TRAIN_EN;
            dv_q    <= strobe;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : gen_lane
        logic [2*RATIO-1:0] hist;
        logic [2*RATIO-1:0] hist_nxt;
        logic [RATIO-1:0]   word_q;
        state_t             state, state_n;
        logic [OW-1:0]      off, off_n;
        logic [MW-1:0]      match_cnt, match_n;
        logic [SW-1:0]      slip_cnt, slip_n;
        logic               err, err_n;

        assign hist_nxt = {hist[2*RATIO-3:0], Q1[n], Q2[n]};

        always_ff @(posedge C or negedge RN) begin
            if (!RN) begin
                hist      <= '0;
                word_q    <= '0;
                state     <= S_IDLE;
                off       <= '0;
                match_cnt <= '0;
                slip_cnt  <= '0;
                err       <= 1'b0;
            end else begin
                if (CE) begin
                    hist <= hist_nxt;
                end
                // Word includes the pair captured on this same edge.
                if (strobe) begin
                    word_q <= hist_nxt[off +: RATIO];
                end
                state     <= state_n;
                off       <= off_n;
                match_cnt <= match_n;
                slip_cnt  <= slip_n;
                err       <= err_n;
            end
        end

        always_comb begin
            state_n = state;
            off_n   = off;
            match_n = match_cnt;
            slip_n  = slip_cnt;
            err_n   = err;
            if (CE) begin
                if (train_rise) begin
                    state_n = S_CHECK;
                    match_n = '0;
                    slip_n  = '0;
                    err_n   = 1'b0;
                end else begin
                    case (state)
                        S_CHECK: begin
                            if (!TRAIN_EN) begin
                                state_n = S_IDLE;
                            end else if (DATA_VALID) begin
                                if (word_q == TRAIN_PATTERN) begin
                                    match_n = match_cnt + 1'b1;
                                    if (match_n == MW'(LOCK_COUNT)) begin
                                        state_n = S_LOCK;
                                    end
                                end else begin
                                    match_n = '0;
                                    off_n   = (off == OW'(RATIO - 1)) ? '0 : off + 1'b1;
                                    slip_n  = slip_cnt + 1'b1;
                                    if (slip_n == SW'(RATIO)) begin
                                        state_n = S_FAIL;
                                        err_n   = 1'b1;
                                    end
                                end
                            end
                        end
                        S_FAIL: begin
                            if (!TRAIN_EN) begin
                                state_n = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign DATA_OUT[n*RATIO +: RATIO] = word_q;
        assign OFFSET[n*OW +: OW]         = off;
        assign LOCKED[n]                  = (state == S_LOCK);
        assign ERROR[n]                   = err;
    end

endmodule
